// File: rtl/sdio_data_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sdio_data_sequencer                                      |
// | Description : CMD53 data-phase sequencer; splits byte/block transfers  |
// |               into PHY activations with gaps, abort and error handling.|
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module sdio_data_sequencer #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_x2,
  input  logic       rst,
  input  logic       i_xfer_start,
  input  logic       i_xfer_write,
  input  logic       i_xfer_block_mode,
  input  logic [8:0] i_xfer_count,
  input  logic [9:0] i_block_size,
  input  logic       i_abort,
  input  logic       i_phy_done,
  input  logic       i_phy_crc_err,
  output logic       o_phy_activate,
  output logic       o_phy_write_flag,
  output logic [9:0] o_phy_data_count,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [1:0] o_status,
  output logic [8:0] o_blocks_done
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_active = 3'd1;
  localparam logic [2:0] c_st_gap    = 3'd2;
  localparam logic [2:0] c_st_done   = 3'd3;
  localparam logic [2:0] c_st_error  = 3'd4;

  localparam logic [1:0] c_status_ok      = 2'b00;
  localparam logic [1:0] c_status_abort   = 2'b01;
  localparam logic [1:0] c_status_crc     = 2'b10;
  localparam logic [1:0] c_status_timeout = 2'b11;

  localparam logic [15:0] c_timeout  = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] c_gap_last = 16'(GAP_CYCLES - 1);
  localparam logic [8:0]  c_blk_max  = 9'd511;

  logic [2:0]  r_state;
  logic [8:0]  r_remaining;
  logic        r_infinite;
  logic [15:0] r_timer;
  logic [15:0] r_gap_cnt;

  logic [2:0]  w_next_state;
  logic        w_block_ok;
  logic        w_set_status;
  logic [1:0]  w_status_val;
  logic [9:0]  w_len;
  logic        w_accept;

  assign w_accept = (r_state == c_st_idle) && i_xfer_start;

  // A zero count or size encodes the full 512-byte length.
  always_comb begin
    w_len = 10'd512;
    if (i_xfer_block_mode) begin
      if (i_block_size != 10'd0) w_len = i_block_size;
    end else begin
      if (i_xfer_count != 9'd0) w_len = {1'b0, i_xfer_count};
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_block_ok   = 1'b0;
    w_set_status = 1'b0;
    w_status_val = c_status_ok;
    case (r_state)
      c_st_idle: begin
        if (i_xfer_start) w_next_state = c_st_active;
      end
      c_st_active: begin
        // Abort outranks CRC error and timeout but still credits a clean block.
        if (i_abort) begin
          w_next_state = c_st_done;
          w_set_status = 1'b1;
          w_status_val = c_status_abort;
          w_block_ok   = i_phy_done && !i_phy_crc_err;
        end else if (i_phy_done && i_phy_crc_err) begin
          w_next_state = c_st_error;
          w_set_status = 1'b1;
          w_status_val = c_status_crc;
        end else if (i_phy_done) begin
          w_block_ok = 1'b1;
          if (!r_infinite && (r_remaining == 9'd1)) begin
            w_next_state = c_st_done;
            w_set_status = 1'b1;
            w_status_val = c_status_ok;
          end else begin
            w_next_state = c_st_gap;
          end
        end else if (r_timer == c_timeout) begin
          w_next_state = c_st_error;
          w_set_status = 1'b1;
          w_status_val = c_status_timeout;
        end
      end
      c_st_gap: begin
        if (i_abort) begin
          w_next_state = c_st_done;
          w_set_status = 1'b1;
          w_status_val = c_status_abort;
        end else if (r_gap_cnt == c_gap_last) begin
          w_next_state = c_st_active;
        end
      end
      c_st_done:  w_next_state = c_st_idle;
      c_st_error: w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_ff @(posedge clk_x2) begin
    if (rst) begin
      r_state          <= c_st_idle;
      r_remaining      <= '0;
      r_infinite       <= 1'b0;
      r_timer          <= '0;
      r_gap_cnt        <= '0;
      o_phy_activate   <= 1'b0;
      o_phy_write_flag <= 1'b0;
      o_phy_data_count <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
      o_status         <= c_status_ok;
      o_blocks_done    <= '0;
    end else begin
      r_state        <= w_next_state;
      o_busy         <= (w_next_state != c_st_idle);
      o_phy_activate <= (w_next_state == c_st_active);
      o_done         <= (w_next_state == c_st_done);
      o_error        <= (w_next_state == c_st_error);

      // Both counters restart from zero on every entry to their state.
      if (r_state != c_st_active) r_timer <= '0;
      else                        r_timer <= r_timer + 16'd1;
      if (r_state != c_st_gap)    r_gap_cnt <= '0;
      else                        r_gap_cnt <= r_gap_cnt + 16'd1;

      if (w_accept) begin
        o_phy_write_flag <= i_xfer_write;
        o_phy_data_count <= w_len - 10'd1;
        r_remaining      <= i_xfer_block_mode ? i_xfer_count : 9'd1;
        r_infinite       <= i_xfer_block_mode && (i_xfer_count == 9'd0);
        o_blocks_done    <= '0;
        o_status         <= c_status_ok;
      end else begin
        if (w_block_ok) begin
          if (o_blocks_done != c_blk_max) o_blocks_done <= o_blocks_done + 9'd1;
          if (!r_infinite) r_remaining <= r_remaining - 9'd1;
        end
        if (w_set_status) o_status <= w_status_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdio_data_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_sdio_data_sequencer                                   |
// | Description : Directed and randomized self-checking bench.             |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module tb_sdio_data_sequencer;

  localparam int GAP     = 4;
  localparam int TIMEOUT = 100;

  logic       clk_x2 = 1'b0;
  logic       rst;
  logic       i_xfer_start;
  logic       i_xfer_write;
  logic       i_xfer_block_mode;
  logic [8:0] i_xfer_count;
  logic [9:0] i_block_size;
  logic       i_abort;
  logic       i_phy_done;
  logic       i_phy_crc_err;
  logic       o_phy_activate;
  logic       o_phy_write_flag;
  logic [9:0] o_phy_data_count;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [1:0] o_status;
  logic [8:0] o_blocks_done;

  int n_cmp  = 0;
  int n_fail = 0;

  sdio_data_sequencer #(
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_x2           (clk_x2),
    .rst              (rst),
    .i_xfer_start     (i_xfer_start),
    .i_xfer_write     (i_xfer_write),
    .i_xfer_block_mode(i_xfer_block_mode),
    .i_xfer_count     (i_xfer_count),
    .i_block_size     (i_block_size),
    .i_abort          (i_abort),
    .i_phy_done       (i_phy_done),
    .i_phy_crc_err    (i_phy_crc_err),
    .o_phy_activate   (o_phy_activate),
    .o_phy_write_flag (o_phy_write_flag),
    .o_phy_data_count (o_phy_data_count),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_error          (o_error),
    .o_status         (o_status),
    .o_blocks_done    (o_blocks_done)
  );

  always #5 clk_x2 = ~clk_x2;

  task automatic step();
    @(posedge clk_x2);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes per PHY activation, from the transfer fields.
  function automatic int model_len(input bit bm, input int cnt, input int sz);
    if (bm) return (sz == 0) ? 512 : sz;
    return (cnt == 0) ? 512 : cnt;
  endfunction

  task automatic start_xfer(input bit wr, input bit bm, input int cnt, input int sz);
    i_xfer_write      = wr;
    i_xfer_block_mode = bm;
    i_xfer_count      = 9'(cnt);
    i_block_size      = 10'(sz);
    i_xfer_start      = 1'b1;
    step();
    i_xfer_start = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_act", o_phy_activate, 1);
    check("start_wflag", o_phy_write_flag, wr);
    check("start_dcnt", o_phy_data_count, model_len(bm, cnt, sz) - 1);
    check("start_bdone", o_blocks_done, 0);
    check("start_status", o_status, 0);
  endtask

  task automatic phy_pulse(input bit crc, input bit abrt);
    i_phy_done    = 1'b1;
    i_phy_crc_err = crc;
    i_abort       = abrt;
    step();
    i_phy_done    = 1'b0;
    i_phy_crc_err = 1'b0;
    i_abort       = 1'b0;
  endtask

  task automatic hold_active(input int d);
    repeat (d) step();
    check("act_hold", o_phy_activate, 1);
  endtask

  // Called in the first low cycle after a clean block; measures the gap.
  task automatic gap_then_active(input int len, input bit wr);
    int low = 1;
    while (o_phy_activate !== 1'b1 && low <= GAP + 4) begin
      step();
      if (o_phy_activate !== 1'b1) low++;
    end
    check("gap_len", low, GAP);
    check("gap_act", o_phy_activate, 1);
    check("gap_dcnt", o_phy_data_count, len - 1);
    check("gap_wflag", o_phy_write_flag, wr);
  endtask

  task automatic finish_ok(input int nblk);
    check("end_done", o_done, 1);
    check("end_status", o_status, 0);
    check("end_bdone", o_blocks_done, nblk);
    check("end_act", o_phy_activate, 0);
    step();
    check("end_busy", o_busy, 0);
    check("end_done_clr", o_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr, bm;
    int cnt, sz, len, nb;

    rst = 1'b1; i_xfer_start = 1'b0; i_xfer_write = 1'b0; i_xfer_block_mode = 1'b0;
    i_xfer_count = '0; i_block_size = '0; i_abort = 1'b0; i_phy_done = 1'b0; i_phy_crc_err = 1'b0;
    step(); step();
    check("rst_act", o_phy_activate, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_error, 0);
    check("rst_status", o_status, 0);
    check("rst_bdone", o_blocks_done, 0);
    check("rst_dcnt", o_phy_data_count, 0);
    rst = 1'b0;
    step();

    // Stray done/abort while idle must be ignored.
    phy_pulse(1'b0, 1'b1);
    check("idle_busy", o_busy, 0);
    check("idle_done", o_done, 0);
    check("idle_bdone", o_blocks_done, 0);

    // Byte mode write, 16 bytes.
    start_xfer(1'b1, 1'b0, 16, 0);
    hold_active(3);
    phy_pulse(1'b0, 1'b0);
    finish_ok(1);

    // Block mode read, 3 x 64.
    start_xfer(1'b0, 1'b1, 3, 64);
    for (int k = 1; k <= 3; k++) begin
      hold_active(2 + k);
      phy_pulse(1'b0, 1'b0);
      check("blk_act_low", o_phy_activate, 0);
      if (k < 3) begin
        check("blk_bdone", o_blocks_done, k);
        gap_then_active(64, 1'b0);
      end
    end
    finish_ok(3);

    // Randomized transfers, started back-to-back in the first idle cycle.
    for (int t = 0; t < 8; t++) begin
      wr = 1'($urandom_range(0, 1));
      bm = 1'($urandom_range(0, 1));
      if (bm) begin
        cnt = $urandom_range(1, 3);
        sz  = $urandom_range(0, 512);
        nb  = cnt;
      end else begin
        cnt = (t == 0) ? 0 : $urandom_range(0, 511);
        sz  = $urandom_range(0, 1023);
        nb  = 1;
      end
      len = model_len(bm, cnt, sz);
      start_xfer(wr, bm, cnt, sz);
      for (int k = 1; k <= nb; k++) begin
        hold_active($urandom_range(0, 30));
        phy_pulse(1'b0, 1'b0);
        check("rnd_act_low", o_phy_activate, 0);
        if (k < nb) gap_then_active(len, wr);
      end
      finish_ok(nb);
    end

    // Infinite block mode, size 0; abort inside the fifth gap.
    start_xfer(1'b1, 1'b1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      hold_active(k);
      phy_pulse(1'b0, 1'b0);
      check("inf_bdone", o_blocks_done, k);
      if (k < 5) gap_then_active(512, 1'b1);
    end
    step();
    check("inf_in_gap", o_phy_activate, 0);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("inf_abort_done", o_done, 1);
    check("inf_abort_status", o_status, 1);
    check("inf_abort_bdone", o_blocks_done, 5);
    step();
    check("inf_busy", o_busy, 0);

    // CRC error on block 2 of 4.
    start_xfer(1'b0, 1'b1, 4, 32);
    hold_active(4);
    phy_pulse(1'b0, 1'b0);
    gap_then_active(32, 1'b0);
    hold_active(2);
    phy_pulse(1'b1, 1'b0);
    check("crc_err", o_error, 1);
    check("crc_done", o_done, 0);
    check("crc_status", o_status, 2);
    check("crc_bdone", o_blocks_done, 1);
    check("crc_act", o_phy_activate, 0);
    step();
    check("crc_busy", o_busy, 0);
    check("crc_err_clr", o_error, 0);

    // Timeout, with ignored starts while busy.
    start_xfer(1'b1, 1'b0, 16, 0);
    for (int c = 1; c <= TIMEOUT; c++) begin
      i_xfer_start      = (c % 10 == 3);
      i_xfer_write      = 1'b0;
      i_xfer_block_mode = 1'b1;
      i_xfer_count      = 9'd7;
      i_block_size      = 10'd100;
      step();
    end
    i_xfer_start = 1'b0;
    check("to_pre_err", o_error, 0);
    check("to_pre_act", o_phy_activate, 1);
    step();
    check("to_err", o_error, 1);
    check("to_status", o_status, 3);
    check("to_act", o_phy_activate, 0);
    check("to_dcnt", o_phy_data_count, 15);
    check("to_wflag", o_phy_write_flag, 1);
    check("to_bdone", o_blocks_done, 0);
    step();
    check("to_busy", o_busy, 0);

    // Abort coincident with a clean done on block 1 of 2.
    start_xfer(1'b0, 1'b1, 2, 8);
    hold_active(5);
    phy_pulse(1'b0, 1'b1);
    check("ab_done", o_done, 1);
    check("ab_err", o_error, 0);
    check("ab_status", o_status, 1);
    check("ab_bdone", o_blocks_done, 1);
    check("ab_act", o_phy_activate, 0);
    step();
    check("ab_busy", o_busy, 0);

    // Back-to-back start, then reset mid-ACTIVE.
    start_xfer(1'b1, 1'b1, 2, 20);
    hold_active(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_act", o_phy_activate, 0);
    check("mrst_busy", o_busy, 0);
    check("mrst_done", o_done, 0);
    check("mrst_err", o_error, 0);
    check("mrst_wflag", o_phy_write_flag, 0);
    check("mrst_dcnt", o_phy_data_count, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("mrst_quiet", {o_done, o_error, o_busy, o_phy_activate}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
